// File: rtl/spi_byte_receiver.sv
// spi_byte_receiver: SPI mode-0 slave that assembles MOSI bytes in the clk domain.
// Optional MISO transmit path is built when the SPI_MISO_EN macro is defined.
`default_nettype none

module spi_byte_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       miso,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] data_out,
    output logic       data_out_ready,
    output logic [7:0] data_out_count,
    output logic       cs_n_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_hist;
    logic                   post_rst;
    logic                   armed;
    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt;

    logic       sync_sclk;
    logic       sync_mosi;
    logic       sync_cs_n;
    logic       rise;
    logic       fall;
    logic       start;
    logic       byte_done;
    logic [7:0] next_byte;

    assign sync_sclk = sclk_sync[SYNC_STAGES-1];
    assign sync_mosi = mosi_sync[SYNC_STAGES-1];
    assign sync_cs_n = cs_sync[SYNC_STAGES-1];
    assign rise      = sync_sclk & ~sclk_hist;
    assign fall      = ~sync_sclk & sclk_hist;
    assign next_byte = {shift_reg[6:0], sync_mosi};
    assign start     = (state == IDLE) && armed && !sync_cs_n;
    assign byte_done = (state == ACTIVE) && !sync_cs_n && rise && (bit_cnt == 3'd7);
    assign cs_n_out  = sync_cs_n;

    // armed only sets once the first stage has sampled a real high on cs_n after
    // reset, so a chip select held low through reset cannot restart a transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sclk_sync      <= '0;
            mosi_sync      <= '0;
            cs_sync        <= '1;
            sclk_hist      <= 1'b0;
            post_rst       <= 1'b0;
            armed          <= 1'b0;
            shift_reg      <= 8'd0;
            bit_cnt        <= 3'd0;
            data_out       <= 8'd0;
            data_out_ready <= 1'b0;
            data_out_count <= 8'd0;
        end else begin
            sclk_sync      <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync      <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync        <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_hist      <= sync_sclk;
            post_rst       <= 1'b1;
            data_out_ready <= 1'b0;
            if (post_rst && cs_sync[0]) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    shift_reg      <= 8'd0;
                    bit_cnt        <= 3'd0;
                    data_out_count <= 8'd0;
                    if (start) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (sync_cs_n) begin
                        state          <= IDLE;
                        shift_reg      <= 8'd0;
                        bit_cnt        <= 3'd0;
                        data_out_count <= 8'd0;
                    end else if (rise) begin
                        shift_reg <= next_byte;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            data_out       <= next_byte;
                            data_out_ready <= 1'b1;
                            if (data_out_count != 8'd255) begin
                                data_out_count <= data_out_count + 8'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_MISO_EN
    logic [7:0] tx_shift;
    logic       skip_fall;
    logic       tx_load_r;

    // A byte loaded at the strobe already shows its MSB; the fall that trails
    // the last rise of the previous byte must not shift it away.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift  <= 8'd0;
            skip_fall <= 1'b0;
            tx_load_r <= 1'b0;
        end else begin
            tx_load_r <= 1'b0;
            if (state == IDLE) begin
                skip_fall <= 1'b0;
                if (start) begin
                    tx_shift  <= tx_data;
                    tx_load_r <= 1'b1;
                end else begin
                    tx_shift <= 8'd0;
                end
            end else if (sync_cs_n) begin
                tx_shift  <= 8'd0;
                skip_fall <= 1'b0;
            end else if (byte_done) begin
                tx_shift  <= tx_data;
                tx_load_r <= 1'b1;
                skip_fall <= 1'b1;
            end else if (fall) begin
                if (skip_fall) begin
                    skip_fall <= 1'b0;
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    assign miso    = tx_shift[7];
    assign tx_load = tx_load_r;
`else
    logic unused_tx_data;
    assign unused_tx_data = ^tx_data;
    assign miso           = 1'b0;
    assign tx_load        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_receiver.sv
// Randomized bench for spi_byte_receiver with a transaction-level expected-strobe model.
`default_nettype none

module tb_spi_byte_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       miso;
    logic       tx_load;
    logic [7:0] data_out;
    logic       data_out_ready;
    logic [7:0] data_out_count;
    logic       cs_n_out;

    int errors = 0;
    int checks = 0;
    int strobes = 0;
    int loads = 0;
    int exp_loads = 0;
    int max_cnt = 0;
    int byte_idx = 0;
    int half = 5;
    logic [7:0] model_last = 8'd0;
    logic [7:0] cur_tx = 8'd0;
    logic [7:0] last_rx = 8'd0;
    logic       prev_csout = 1'b1;
    logic [7:0] exp_d[$];
    logic [7:0] exp_c[$];

    spi_byte_receiver #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .data_out(data_out),
        .data_out_ready(data_out_ready), .data_out_count(data_out_count),
        .cs_n_out(cs_n_out)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every-cycle comparison against the expected-strobe queue.
    always @(negedge clk) begin
        logic [7:0] d;
        logic [7:0] c;
        if (reset) begin
            model_last = 8'd0;
            exp_d.delete();
            exp_c.delete();
            prev_csout = 1'b1;
        end else begin
            if (data_out_ready) begin
                strobes++;
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_strobe: got data %h count %0d expected no strobe", data_out, data_out_count);
                end else begin
                    d = exp_d.pop_front();
                    c = exp_c.pop_front();
                    check8("strobe_data", data_out, d);
                    check8("strobe_count", data_out_count, c);
                    model_last = d;
                    if (int'(data_out_count) > max_cnt) max_cnt = int'(data_out_count);
                end
            end else begin
                check8("data_hold", data_out, model_last);
            end
`ifdef SPI_MISO_EN
            if (tx_load) loads++;
            if (cs_n_out && prev_csout) check1("miso_idle", miso, 1'b0);
`else
            check1("miso_off", miso, 1'b0);
            check1("tx_load_off", tx_load, 1'b0);
`endif
            prev_csout = cs_n_out;
        end
    end

    task automatic start_txn(input logic [7:0] first_tx);
        tx_data = first_tx;
        cur_tx = first_tx;
        cs_n = 1'b0;
        byte_idx = 0;
        exp_loads++;
        tick(8);
    endtask

    task automatic end_txn();
        tick(8);
        cs_n = 1'b1;
        tick(10);
    endtask

    // Master side of one mode-0 byte; miso is sampled just before each rising edge.
    task automatic send_byte(input logic [7:0] b, input logic [7:0] next_tx, input bit expect_strobe);
        logic [7:0] got;
        got = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            tick(half);
            got[i] = miso;
            sclk = 1'b1;
            if (i == 7) tx_data = next_tx;
            if (i == 0 && expect_strobe) begin
                byte_idx++;
                exp_d.push_back(b);
                exp_c.push_back((byte_idx > 255) ? 8'd255 : 8'(byte_idx));
                exp_loads++;
            end
            tick(half);
            sclk = 1'b0;
        end
        last_rx = got;
`ifdef SPI_MISO_EN
        if (expect_strobe) check8("miso_byte", got, cur_tx);
`endif
        cur_tx = next_tx;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            tick(half);
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
    endtask

    initial begin
        int s0;
        int l0;
        int nb;
        tick(5);
        check8("rst_data_out", data_out, 8'h00);
        check1("rst_ready", data_out_ready, 1'b0);
        check8("rst_count", data_out_count, 8'h00);
        check1("rst_cs_n_out", cs_n_out, 1'b1);
        check1("rst_miso", miso, 1'b0);
        check1("rst_tx_load", tx_load, 1'b0);
        reset = 1'b0;
        tick(6);

        // Single byte, then count returns to zero.
        s0 = strobes;
        start_txn(8'h00);
        send_byte(8'h0A, 8'h00, 1'b1);
        end_txn();
        checki("one_byte_strobes", strobes - s0, 1);
        check8("one_byte_data", data_out, 8'h0A);
        check8("count_cleared", data_out_count, 8'h00);

        // Five bytes in one transaction.
        s0 = strobes;
        start_txn(8'h00);
        send_byte(8'h0A, 8'h00, 1'b1);
        send_byte(8'h00, 8'h00, 1'b1);
        send_byte(8'h00, 8'h00, 1'b1);
        send_byte(8'h10, 8'h00, 1'b1);
        send_byte(8'h55, 8'h00, 1'b1);
        end_txn();
        checki("five_strobes", strobes - s0, 5);
        check8("five_last_data", data_out, 8'h55);

        // Partial byte discarded, next transaction starts at count 1.
        s0 = strobes;
        start_txn(8'h00);
        send_bits(8'hF0, 4);
        end_txn();
        checki("partial_no_strobe", strobes - s0, 0);
        check8("partial_data_kept", data_out, 8'h55);
        start_txn(8'h00);
        send_byte(8'h3C, 8'h00, 1'b1);
        end_txn();
        checki("after_partial_strobe", strobes - s0, 1);
        check8("after_partial_data", data_out, 8'h3C);

`ifdef SPI_MISO_EN
        // Transmit bytes taken at ACTIVE entry and at the first strobe.
        l0 = loads;
        start_txn(8'hA5);
        send_byte(8'h11, 8'h3C, 1'b1);
        check8("miso_first", last_rx, 8'hA5);
        send_byte(8'h22, 8'h00, 1'b1);
        check8("miso_second", last_rx, 8'h3C);
        end_txn();
        checki("tx_load_pulses", loads - l0, 3);
`else
        l0 = 0;
`endif

        // Reset at bit 5 with cs_n held low: no strobe until cs_n toggles.
        s0 = strobes;
        start_txn(8'h00);
        send_bits(8'hC3, 5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        byte_idx = 0;
        check8("midrst_data_out", data_out, 8'h00);
        check1("midrst_ready", data_out_ready, 1'b0);
        check8("midrst_count", data_out_count, 8'h00);
        check1("midrst_cs_n_out", cs_n_out, 1'b1);
        check1("midrst_miso", miso, 1'b0);
        send_bits(8'h00, 3);
        send_byte(8'h99, 8'h00, 1'b0);
        tick(10);
        checki("midrst_no_strobe", strobes - s0, 0);
        cs_n = 1'b1;
        tick(10);
        start_txn(8'h00);
        send_byte(8'h6E, 8'h00, 1'b1);
        end_txn();
        checki("midrst_resume", strobes - s0, 1);
        check8("midrst_resume_data", data_out, 8'h6E);

        // Randomized transactions.
        for (int t = 0; t < 20; t++) begin
            half = $urandom_range(5, 8);
            nb = $urandom_range(1, 4);
            start_txn(8'($urandom));
            for (int k = 0; k < nb; k++) send_byte(8'($urandom), 8'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) send_bits(8'($urandom), $urandom_range(1, 7));
            end_txn();
            tick($urandom_range(0, 6));
        end

        // 257 bytes: count saturates at 255, strobes keep firing.
        half = 5;
        s0 = strobes;
        max_cnt = 0;
        start_txn(8'($urandom));
        for (int k = 0; k < 256; k++) send_byte(8'($urandom), 8'($urandom), 1'b1);
        send_byte(8'hE7, 8'h00, 1'b1);
        tick(10);
        check8("sat_count", data_out_count, 8'd255);
        end_txn();
        checki("sat_strobes", strobes - s0, 257);
        checki("sat_max_count", max_cnt, 255);
        check8("sat_last_data", data_out, 8'hE7);

        checki("pending_strobes", exp_d.size(), 0);
`ifdef SPI_MISO_EN
        checki("total_tx_loads", loads, exp_loads);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_byte_receiver.md
SPI_BYTE_RECEIVER -- requirements
Module: spi_byte_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sclk, mosi and cs_n; the legal range is 2..4.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 sclk  input  1  SPI serial clock from the external master, asynchronous to clk, SPI mode 0.
REQ-005 mosi  input  1  SPI serial data in, MSB first.
REQ-006 cs_n  input  1  SPI chip select, asynchronous, active-low.
REQ-007 miso  output  1  SPI serial data out, MSB first.
REQ-008 tx_data  input  8  byte to shift out on miso during the next byte slot.
REQ-009 tx_load  output  1  one-cycle pulse when tx_data is captured.
REQ-010 data_out  output  8  last complete received byte.
REQ-011 data_out_ready  output  1  one-cycle strobe that data_out is valid.
REQ-012 data_out_count  output  8  1-based index of the byte in the current transaction.
REQ-013 cs_n_out  output  1  synchronized cs_n, for downstream blocks that gate on chip select.

Function
REQ-014 sclk, mosi and cs_n shall each pass through SYNC_STAGES flops, plus one history flop for edge detection.
REQ-015 A rise event is sync_sclk going 0->1; a fall event is sync_sclk going 1->0.
REQ-016 FSM states: IDLE (sync cs_n high) and ACTIVE (sync cs_n low).
REQ-017 IDLE->ACTIVE shall occur on the cycle sync cs_n is first seen low.
REQ-018 ACTIVE->IDLE shall occur on the cycle sync cs_n is first seen high.
REQ-019 In ACTIVE, each rise event shall shift sync mosi into the LSB of an 8-bit shift register and increment a 3-bit bit counter.
REQ-020 On the rise event that completes bit 7 (counter 7->0 wrap), on the next clk cycle: data_out shall equal the assembled byte, data_out_ready shall be 1 for exactly one cycle, and data_out_count shall be incremented.
REQ-021 Latency from the sync_sclk rise of bit 7 to data_out_ready shall be one clk.
REQ-022 data_out_count shall be 1 for the first byte of a transaction.
REQ-023 data_out_count shall saturate at 255 and never wrap to 0.
REQ-024 data_out shall hold its value until the next completed byte and shall not be cleared by cs_n.
REQ-025 Entering IDLE shall clear the bit counter, the shift register and data_out_count; a partial byte is discarded with no strobe.
REQ-026 If the bit-7 rise event and cs_n deassertion are seen in the same cycle, cs_n wins: no strobe and no count increment.
REQ-027 Rise or fall events while in IDLE shall be ignored.
REQ-028 cs_n_out shall equal the final synchronizer stage of cs_n.

Reset
REQ-029 While reset is 1 at a clk edge: state is IDLE, all synchronizer flops are 1 for cs_n and 0 for sclk and mosi, shift registers and counters are 0, data_out=0, data_out_ready=0, data_out_count=0, tx_load=0, miso=0, cs_n_out=1.
REQ-030 Reset asserted mid-byte shall abort the byte with no strobe.
REQ-031 After reset release, the block shall require a sync cs_n high-to-low transition to re-enter ACTIVE.

Configuration
REQ-032 Macro SPI_MISO_EN: when defined, the transmit path shall be built.
REQ-033 With SPI_MISO_EN, tx_data shall be captured with a one-cycle tx_load pulse on the IDLE->ACTIVE cycle and on every data_out_ready cycle.
REQ-034 With SPI_MISO_EN, miso shall present the captured byte's MSB immediately and shift to the next bit on each fall event in ACTIVE.
REQ-035 With SPI_MISO_EN, miso shall be 0 in IDLE.
REQ-036 Without SPI_MISO_EN, miso and tx_load shall be constant 0, tx_data shall be ignored, and no transmit flops shall exist.

Verification
REQ-037 cs_n low, mode-0 byte 0x0A, cs_n high -> one data_out_ready pulse, data_out=0x0A, data_out_count=1; count returns to 0 after cs_n high.
REQ-038 Five bytes 0x0A,0x00,0x00,0x10,0x55 in one transaction -> five strobes, counts 1..5, data matching each byte.
REQ-039 Four bits of 0xF0, then cs_n high, then a new transaction with 0x3C -> no strobe for the partial byte; strobe with 0x3C, count=1.
REQ-040 Preload 255 count via 256 bytes, then send a 257th byte -> data_out_count stays 255; strobe still fires.
REQ-041 SPI_MISO_EN defined, tx_data=0xA5 at cs_n low, 0x3C at first strobe -> master samples 0xA5 then 0x3C; tx_load pulses at the ACTIVE entry and at the first strobe.
REQ-042 reset=1 for one clk at bit 5 of a byte -> all outputs at reset values; no strobe until cs_n toggles high then low.
